// File: rtl/top.sv
// rtl/top.sv - rotary dial tracker counting passes through position 0.
// TOP_END_ONLY_EN: count only rotations that finish on position 0.
module top #(
    parameter int DIAL_SIZE = 100,
    parameter int START_POS = 50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] n,
    output logic signed [31:0] c
);

    localparam int         XW     = 10;
    localparam logic [32:0] DIAL_W = 33'(DIAL_SIZE);

    logic [XW-1:0] x;
    logic [XW-1:0] x_d;
    logic [31:0]   c_q;
    logic [31:0]   c_d;
    logic [31:0]   m;
    logic [32:0]   m_ext;
    logic [32:0]   s;
    logic [XW-1:0] r;
    logic [31:0]   hits;

    always_comb begin
        // |n| as unsigned; -2^31 maps to 2^31 through two's-complement negation
        m     = n[31] ? (~n + 32'd1) : n;
        m_ext = {1'b0, m};
        s     = m_ext + {{(33 - XW){1'b0}}, x};
        r     = '0;
        x_d   = x;
        hits  = '0;
        if (!n[31]) begin
            x_d  = XW'(s % DIAL_W);
            hits = 32'(s / DIAL_W);
        end else begin
            r    = XW'(m_ext % DIAL_W);
            hits = 32'(m_ext / DIAL_W) + {31'b0, (x != '0) && (r >= x)};
            // borrow wraps back into the top of the dial; result is below DIAL_SIZE
            x_d  = (r > x) ? (x + XW'(DIAL_SIZE) - r) : (x - r);
        end
`ifdef TOP_END_ONLY_EN
        c_d = c_q + {31'b0, (n != 32'sd0) && (x_d == '0)};
`else
        c_d = c_q + hits;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x   <= XW'(START_POS);
            c_q <= '0;
        end else begin
            x   <= x_d;
            c_q <= c_d;
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed self-checking bench for the dial tracker.
module tb_top;

    logic               clk;
    logic               reset;
    logic signed [31:0] n;
    logic signed [31:0] c;

    int n_checks;
    int n_errors;

`ifdef TOP_END_ONLY_EN
    localparam bit END_ONLY = 1'b1;
`else
    localparam bit END_ONLY = 1'b0;
`endif

    top dut (
        .clk   (clk),
        .reset (reset),
        .n     (n),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic signed [31:0] cmd);
        n = cmd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        n     = 32'sd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_x, input logic [31:0] exp_c);
        check({tag, ".x"}, 32'(dut.x), exp_x);
        check({tag, ".c"}, c, exp_c);
    endtask

    int seq_n  [10] = '{-68, -30, 48, -5, 60, -55, -1, -99, 14, -82};
    int seq_x  [10] = '{82, 52, 0, 95, 55, 0, 99, 0, 14, 32};
    int seq_c  [10] = '{1, 1, 2, 2, 3, 4, 4, 5, 5, 6};
    int seq_ce [10] = '{0, 0, 1, 1, 1, 2, 2, 3, 3, 3};

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        n        = 32'sd0;

        do_reset();
        check_state("reset", 50, 0);

        for (int i = 0; i < 10; i++) begin
            step(seq_n[i]);
            check_state($sformatf("seq%0d", i), seq_x[i], END_ONLY ? seq_ce[i] : seq_c[i]);
        end

        do_reset();
        step(1000);
        check_state("plus1000", 50, END_ONLY ? 0 : 10);
        step(-1000);
        check_state("minus1000", 50, END_ONLY ? 0 : 20);

        do_reset();
        step(-50);
        check_state("land_zero", 0, 1);
        step(-5);
        check_state("leave_zero", 95, 1);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0);
            check_state($sformatf("noop%0d", i), 50, 0);
        end

        do_reset();
        step(60);
        check_state("plus60", 10, END_ONLY ? 0 : 1);
        reset = 1'b1;
        step(90);
        reset = 1'b0;
        check_state("mid_reset", 50, 0);

        do_reset();
        step(-32'sd2147483648);
        check_state("min_int", 2, END_ONLY ? 0 : 21474836);

        do_reset();
        step(32'sd2147483647);
        check_state("max_int", 97, END_ONLY ? 0 : 21474836);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
